// File: rtl/crc_arbiter.sv
// crc_arbiter
//   Two-requester round-robin front end for a shared combinational CRC engine.
//   A granted requester streams beats through the engine. The running CRC is
//   kept between beats, and the final CRC and beat count are posted as a
//   per-requester result that is held until that requester accepts it.
//
// Ports
//   ACLK, ARESETn            clock, synchronous active-low reset
//   crc_init                 seed applied to the first beat of each packet
//   req_valid/req_last[1:0]  per-requester beat valid / final-beat flag
//   req_data0, req_data1     per-requester beat data
//   req_ready[1:0]           per-requester beat accept
//   res_valid[1:0]           per-requester result valid
//   res_ready[1:0]           per-requester result accept
//   res_crc0/1, res_len0/1   per-requester final CRC and beat count
//   eng_crc_in, eng_data     operands to the external CRC engine
//   eng_crc_out              engine result (same-cycle function of operands)
//   busy                     a packet currently holds the grant
//   grant                    requester holding, or last holding, the grant
module crc_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [DATA_WIDTH-1:0] crc_init,
  input  logic [1:0]            req_valid,
  input  logic [DATA_WIDTH-1:0] req_data0,
  input  logic [DATA_WIDTH-1:0] req_data1,
  input  logic [1:0]            req_last,
  output logic [1:0]            req_ready,
  output logic [1:0]            res_valid,
  output logic [DATA_WIDTH-1:0] res_crc0,
  output logic [DATA_WIDTH-1:0] res_crc1,
  output logic [LEN_WIDTH-1:0]  res_len0,
  output logic [LEN_WIDTH-1:0]  res_len1,
  input  logic [1:0]            res_ready,
  output logic [DATA_WIDTH-1:0] eng_crc_in,
  output logic [DATA_WIDTH-1:0] eng_data,
  input  logic [DATA_WIDTH-1:0] eng_crc_out,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nxt;
  logic                  last_winner;
  logic                  first_beat;
  logic [DATA_WIDTH-1:0] run_crc;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [1:0]            eligible;
  logic                  grant_nxt;
  logic                  start;
  logic                  accept;
  logic                  accept_last;

  // A requester whose previous result is still unconsumed sits out arbitration.
  assign eligible = req_valid & ~res_valid;
  assign busy     = (state == BUSY);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    start       = 1'b0;
    req_ready   = '0;
    accept      = 1'b0;
    accept_last = 1'b0;
    eng_data    = grant ? req_data1 : req_data0;
    eng_crc_in  = first_beat ? crc_init : run_crc;
    unique case (state)
      IDLE: begin
        if (eligible != 2'b00) begin
          start     = 1'b1;
          state_nxt = BUSY;
          // On a tie the requester that did not finish last wins.
          if (eligible == 2'b11) grant_nxt = ~last_winner;
          else                   grant_nxt = eligible[1];
        end
      end
      BUSY: begin
        req_ready   = grant ? 2'b10 : 2'b01;
        accept      = req_valid[grant];
        accept_last = accept & req_last[grant];
        if (accept_last) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      grant       <= 1'b0;
      last_winner <= 1'b1;
      first_beat  <= 1'b0;
      run_crc     <= '0;
      beat_cnt    <= '0;
      res_valid   <= '0;
      res_crc0    <= '0;
      res_crc1    <= '0;
      res_len0    <= '0;
      res_len1    <= '0;
    end else begin
      grant     <= grant_nxt;
      res_valid <= res_valid & ~res_ready;
      if (start) begin
        first_beat <= 1'b1;
        beat_cnt   <= '0;
      end
      if (accept) begin
        first_beat <= 1'b0;
        if (accept_last) begin
          // res_valid[grant] is known clear here, so the set cannot race a clear.
          last_winner      <= grant;
          res_valid[grant] <= 1'b1;
          if (grant) begin
            res_crc1 <= eng_crc_out;
            res_len1 <= beat_cnt + 1'b1;
          end else begin
            res_crc0 <= eng_crc_out;
            res_len0 <= beat_cnt + 1'b1;
          end
        end else begin
          run_crc  <= eng_crc_out;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_arbiter.sv
module tb_crc_arbiter;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [DW-1:0] crc_init;
  logic [1:0]    req_valid, req_last, req_ready, res_valid, res_ready;
  logic [DW-1:0] req_data0, req_data1, res_crc0, res_crc1;
  logic [LW-1:0] res_len0, res_len1;
  logic [DW-1:0] eng_crc_in, eng_data, eng_crc_out;
  logic          busy, grant;

  // Engine stub: XOR of seed and data.
  assign eng_crc_out = eng_crc_in ^ eng_data;

  crc_arbiter #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .crc_init(crc_init),
    .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
    .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid),
    .res_crc0(res_crc0), .res_crc1(res_crc1), .res_len0(res_len0),
    .res_len1(res_len1), .res_ready(res_ready), .eng_crc_in(eng_crc_in),
    .eng_data(eng_data), .eng_crc_out(eng_crc_out), .busy(busy), .grant(grant)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int passed = 0;

  // Reference model: per-requester beat queues, expected results per packet,
  // and a transaction-level view of who owns the engine.
  logic [DW-1:0] word_q[2][$];
  bit            last_q[2][$];
  logic [DW-1:0] exp_crc_q[2][$];
  logic [LW-1:0] exp_len_q[2][$];
  logic [DW-1:0] stage_q[$];
  bit            pend[2];
  bit            hold[2];
  bit            m_busy, m_grant, lastw;
  int            stall_pct;
  int            rdy_pct[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      word_q[i].delete(); last_q[i].delete();
      exp_crc_q[i].delete(); exp_len_q[i].delete();
      pend[i] = 1'b0; hold[i] = 1'b0;
    end
    stage_q.delete();
    m_busy = 1'b0; m_grant = 1'b0; lastw = 1'b1;
  endtask

  // Packet CRC is the seed XORed with every word; length is modulo 2^LW.
  task automatic commit(input int i);
    logic [DW-1:0] c;
    c = crc_init;
    foreach (stage_q[k]) begin
      c = c ^ stage_q[k];
      word_q[i].push_back(stage_q[k]);
      last_q[i].push_back(k == stage_q.size() - 1);
    end
    exp_crc_q[i].push_back(c);
    exp_len_q[i].push_back(LW'(stage_q.size()));
    stage_q.delete();
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_busy);
    chk("grant", grant, m_grant);
    chk("req_ready", req_ready, m_busy ? (m_grant ? 2'b10 : 2'b01) : 2'b00);
    chk("res_valid", res_valid, {pend[1], pend[0]});
    if (pend[0]) begin
      chk("res_crc0", res_crc0, exp_crc_q[0][0]);
      chk("res_len0", res_len0, exp_len_q[0][0]);
    end
    if (pend[1]) begin
      chk("res_crc1", res_crc1, exp_crc_q[1][0]);
      chk("res_len1", res_len1, exp_len_q[1][0]);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_crc0"}, res_crc0, 0);
    chk({tag, "_res_crc1"}, res_crc1, 0);
    chk({tag, "_res_len0"}, res_len0, 0);
    chk({tag, "_res_len1"}, res_len1, 0);
  endtask

  task automatic do_reset(input string tag);
    ARESETn = 1'b0; req_valid = '0; res_ready = '0;
    @(posedge ACLK); #1;
    mreset();
    check_reset(tag);
    ARESETn = 1'b1;
  endtask

  // One clock: check outputs, drive inputs, advance the model across the edge.
  task automatic step();
    logic [1:0] v, rr, elig;
    bit fin;
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      v[i]  = (word_q[i].size() > 0) && !hold[i] && (int'($urandom_range(99)) >= stall_pct);
      rr[i] = int'($urandom_range(99)) < rdy_pct[i];
    end
    req_valid = v; res_ready = rr;
    if (v[0]) begin req_data0 = word_q[0][0]; req_last[0] = last_q[0][0]; end
    else begin req_data0 = $urandom(); req_last[0] = 1'($urandom()); end
    if (v[1]) begin req_data1 = word_q[1][0]; req_last[1] = last_q[1][0]; end
    else begin req_data1 = $urandom(); req_last[1] = 1'($urandom()); end
    @(posedge ACLK); #1;
    elig = v & ~{pend[1], pend[0]};
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && rr[i]) begin
        pend[i] = 1'b0;
        void'(exp_crc_q[i].pop_front());
        void'(exp_len_q[i].pop_front());
      end
    end
    if (!m_busy) begin
      if (elig != 2'b00) begin
        m_busy  = 1'b1;
        m_grant = (elig == 2'b11) ? !lastw : elig[1];
      end
    end else if (v[m_grant]) begin
      fin = last_q[m_grant][0];
      void'(word_q[m_grant].pop_front());
      void'(last_q[m_grant].pop_front());
      if (fin) begin
        pend[m_grant] = 1'b1;
        lastw  = m_grant;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic wait_res(input int i, input int budget);
    int n;
    n = 0;
    while (!res_valid[i] && n < budget) begin step(); n++; end
    chk("wait_res", res_valid[i], 1);
  endtask

  task automatic drain(input int budget);
    int n;
    bit open;
    n = 0;
    open = 1'b1;
    while (open && n < budget) begin
      open = (word_q[0].size() > 0) || (word_q[1].size() > 0) || m_busy || pend[0] || pend[1];
      if (open) begin step(); n++; end
    end
    chk("drain_done", open, 0);
  endtask

  initial begin
    int n;
    ARESETn = 1'b0; req_valid = '0; req_last = '0; req_data0 = '0; req_data1 = '0;
    res_ready = '0; crc_init = '0;
    stall_pct = 0; rdy_pct = '{100, 100};
    mreset();
    do_reset("por");
    do_reset("por2");

    // Two-beat packet from requester 0.
    crc_init = 32'hFFFF_FFFF; rdy_pct = '{0, 0};
    stage_q.push_back(32'h0000_0001); stage_q.push_back(32'h0000_0010); commit(0);
    wait_res(0, 20);
    chk("two_beat_crc", res_crc0, 32'hFFFF_FFEE);
    chk("two_beat_len", res_len0, 2);
    rdy_pct = '{100, 100}; drain(20);

    // Tie after reset goes to requester 0, then alternation.
    do_reset("rr_rst");
    crc_init = '0;
    stage_q.push_back(32'hA); commit(0);
    stage_q.push_back(32'hB); commit(1);
    step(); chk("tie_first_grant", grant, 0); chk("tie_first_busy", busy, 1);
    step(); step(); chk("second_grant", grant, 1); chk("second_busy", busy, 1);
    drain(30);
    stage_q.push_back(32'hC); commit(0);
    stage_q.push_back(32'hD); commit(1);
    step(); chk("alt_grant", grant, 0);
    drain(30);

    // Unconsumed result blocks its owner only.
    crc_init = '0; rdy_pct = '{0, 0};
    stage_q.push_back(32'h1234_5678); commit(0);
    wait_res(0, 20);
    chk("single_crc", res_crc0, 32'h1234_5678);
    chk("single_len", res_len0, 1);
    stage_q.push_back(32'h1111); commit(0);
    stage_q.push_back(32'h2222); commit(1);
    repeat (5) step();
    chk("held_valid", res_valid, 2'b11);
    chk("held_crc0", res_crc0, 32'h1234_5678);
    chk("held_len0", res_len0, 1);
    chk("other_crc1", res_crc1, 32'h2222);
    rdy_pct = '{100, 100}; drain(40);

    // Mid-packet stall on requester 1 while requester 0 waits.
    crc_init = 32'hC0DE_0000; rdy_pct = '{100, 0};
    for (int k = 1; k <= 4; k++) stage_q.push_back(DW'(k));
    commit(1);
    stage_q.push_back(32'h7777); commit(0);
    n = 0;
    while (word_q[1].size() > 2 && n < 20) begin step(); n++; end
    hold[1] = 1'b1;
    repeat (3) begin
      step();
      chk("stall_ready", req_ready, 2'b10);
      chk("stall_grant", grant, 1);
    end
    hold[1] = 1'b0;
    wait_res(1, 20);
    chk("stall_crc", res_crc1, 32'hC0DE_0004);
    chk("stall_len", res_len1, 4);
    rdy_pct = '{100, 100}; drain(40);

    // Reset in the middle of a packet.
    crc_init = 32'h5555_AAAA;
    for (int k = 1; k <= 4; k++) stage_q.push_back(DW'(k * 10));
    commit(0);
    n = 0;
    while (word_q[0].size() > 2 && n < 20) begin step(); n++; end
    do_reset("mid_rst");
    crc_init = 32'hA5A5_A5A5; rdy_pct = '{0, 0};
    stage_q.push_back(32'h0000_FFFF); commit(0);
    wait_res(0, 20);
    chk("post_rst_crc", res_crc0, 32'hA5A5_5A5A);
    chk("post_rst_len", res_len0, 1);
    rdy_pct = '{100, 100}; drain(20);

    // Randomized traffic with stalls, back-pressure and length wrap.
    stall_pct = 30; rdy_pct = '{60, 60}; crc_init = $urandom();
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 2; i++) begin
        n = int'($urandom_range(20, 1));
        for (int k = 0; k < n; k++) stage_q.push_back($urandom());
        commit(i);
      end
    end
    drain(20000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
